// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide share one 2W accumulator.
// Latency is fixed: DATA_WIDTH+1 cycles for normal operations, 1 cycle for
// divide-by-zero and signed overflow, which are resolved at accept time.
module muldiv_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int FUNC3_WIDTH = 3,
   parameter int REG_SIZE    = 5
) (
   input  logic                   clk,
   input  logic                   rstN,
   input  logic                   start,
   input  logic [FUNC3_WIDTH-1:0] func3,
   input  logic [DATA_WIDTH-1:0]  rs1Data,
   input  logic [DATA_WIDTH-1:0]  rs2Data,
   input  logic [REG_SIZE-1:0]    rdIn,
   input  logic                   flush,
   output logic                   ready,
   output logic                   busy,
   output logic                   valid,
   output logic [DATA_WIDTH-1:0]  result,
   output logic [REG_SIZE-1:0]    rdOut
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                    state;
   logic [CNT_W-1:0]          counter;
   logic [FUNC3_WIDTH-1:0]    opReg;
   logic [REG_SIZE-1:0]       tagReg;
   logic [DATA_WIDTH-1:0]     operandReg;   // multiplicand (mul) or divisor (div) magnitude
   logic [2*DATA_WIDTH-1:0]   acc;          // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
   logic                      negQ;         // product sign (mul) or quotient sign (div)
   logic                      negR;         // remainder sign = dividend sign

   // Operand decode at accept time
   logic                      isDiv;
   logic                      aSigned;
   logic                      bSigned;
   logic                      aNeg;
   logic                      bNeg;
   logic [DATA_WIDTH-1:0]     aMag;
   logic [DATA_WIDTH-1:0]     bMag;
   logic                      divByZero;
   logic                      divOverflow;
   logic                      isSpecial;
   logic [DATA_WIDTH-1:0]     specialRes;

   assign isDiv   = func3[2];
   // MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned; DIV/REM signed, DIVU/REMU unsigned
   assign aSigned = isDiv ? ~func3[0] : (func3[1:0] != 2'b11);
   assign bSigned = isDiv ? ~func3[0] : ~func3[1];
   assign aNeg    = aSigned & rs1Data[DATA_WIDTH-1];
   assign bNeg    = bSigned & rs2Data[DATA_WIDTH-1];
   assign aMag    = aNeg ? -rs1Data : rs1Data;
   assign bMag    = bNeg ? -rs2Data : rs2Data;

   assign divByZero   = isDiv && (rs2Data == '0);
   assign divOverflow = isDiv && ~func3[0] && (rs1Data == MOST_NEG) && (rs2Data == '1);
   assign isSpecial   = divByZero | divOverflow;

   // Divide-by-zero: quotient all ones, remainder = dividend. Overflow: quotient = MOST_NEG, remainder 0.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      specialRes = '0;
      if (divByZero) begin
         specialRes = func3[1] ? rs1Data : '1;
      end else if (divOverflow) begin
         specialRes = func3[1] ? '0 : MOST_NEG;
      end
   end

   // One radix-2 iteration for the operation in flight
   logic [DATA_WIDTH:0]       mulAddend;
   logic [DATA_WIDTH:0]       mulSum;
   logic [2*DATA_WIDTH-1:0]   mulNext;
   logic [DATA_WIDTH:0]       divShift;
   logic                      divGe;
   logic [DATA_WIDTH-1:0]     divRem;
   logic [2*DATA_WIDTH-1:0]   divNext;
   logic [2*DATA_WIDTH-1:0]   accNext;

   assign mulAddend = acc[0] ? {1'b0, operandReg} : '0;
   assign mulSum    = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + mulAddend;
   assign mulNext   = {mulSum, acc[DATA_WIDTH-1:1]};

   // Partial remainder is always below the divisor, so the W-bit difference cannot wrap.
   assign divShift  = {acc[2*DATA_WIDTH-1:DATA_WIDTH], acc[DATA_WIDTH-1]};
   assign divGe     = divShift >= {1'b0, operandReg};
   assign divRem    = divGe ? (divShift[DATA_WIDTH-1:0] - operandReg) : divShift[DATA_WIDTH-1:0];
   assign divNext   = {divRem, acc[DATA_WIDTH-2:0], divGe};

   assign accNext   = opReg[2] ? divNext : mulNext;

   // Sign correction applied on the final CALC step
   logic [2*DATA_WIDTH-1:0]   prodFix;
   logic [DATA_WIDTH-1:0]     quot;
   logic [DATA_WIDTH-1:0]     remd;
   logic [DATA_WIDTH-1:0]     finalRes;

   assign prodFix = negQ ? -accNext : accNext;
   assign quot    = accNext[DATA_WIDTH-1:0];
   assign remd    = accNext[2*DATA_WIDTH-1:DATA_WIDTH];

   always_comb begin
      finalRes = '0;
      if (opReg[2]) begin
         if (opReg[1]) finalRes = negR ? -remd : remd;
         else          finalRes = negQ ? -quot : quot;
      end else begin
         if (opReg[1:0] == 2'b00) finalRes = prodFix[DATA_WIDTH-1:0];
         else                     finalRes = prodFix[2*DATA_WIDTH-1:DATA_WIDTH];
      end
   end

   // Control FSM with registered handshake outputs and datapath state
   always_ff @(posedge clk or negedge rstN) begin
      // NOTE: every register, including the operand/accumulator datapath, is cleared by reset.
      if (!rstN) begin
         state      <= IDLE;
         counter    <= '0;
         opReg      <= '0;
         tagReg     <= '0;
         operandReg <= '0;
         acc        <= '0;
         negQ       <= 1'b0;
         negR       <= 1'b0;
         ready      <= 1'b1;
         busy       <= 1'b0;
         valid      <= 1'b0;
         result     <= '0;
         rdOut      <= '0;
      end else begin
         // NOTE: non-blocking assignments so all state updates use pre-edge values.
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !flush) begin
                  opReg  <= func3;
                  tagReg <= rdIn;
                  ready  <= 1'b0;
                  busy   <= 1'b1;
                  if (isSpecial) begin
                     result <= specialRes;
                     rdOut  <= rdIn;
                     valid  <= 1'b1;
                     state  <= DONE;
                  end else begin
                     operandReg <= isDiv ? bMag : aMag;
                     acc        <= {{DATA_WIDTH{1'b0}}, (isDiv ? aMag : bMag)};
                     negQ       <= aNeg ^ bNeg;
                     negR       <= aNeg;
                     counter    <= CNT_W'(DATA_WIDTH - 1);
                     state      <= CALC;
                  end
               end
            end
            CALC: begin
               if (flush) begin
                  state <= IDLE;
                  ready <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  acc <= accNext;
                  if (counter == '0) begin
                     result <= finalRes;
                     rdOut  <= tagReg;
                     valid  <= 1'b1;
                     state  <= DONE;
                  end else begin
                     counter <= counter - 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors feed a scoreboard
// queue; a negedge monitor pops and compares on every valid pulse, checking
// result, tag and accept-to-valid latency.
module tb_muldiv_unit;

   localparam int W = 32;
   localparam int F = 3;
   localparam int R = 5;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam int LAT_NORMAL  = W + 1;
   localparam int LAT_SPECIAL = 1;

   logic          clk;
   logic          rstN;
   logic          start;
   logic [F-1:0]  func3;
   logic [W-1:0]  rs1Data;
   logic [W-1:0]  rs2Data;
   logic [R-1:0]  rdIn;
   logic          flush;
   logic          ready;
   logic          busy;
   logic          valid;
   logic [W-1:0]  result;
   logic [R-1:0]  rdOut;

   muldiv_unit #(.DATA_WIDTH(W), .FUNC3_WIDTH(F), .REG_SIZE(R)) dut (
      .clk     (clk),
      .rstN    (rstN),
      .start   (start),
      .func3   (func3),
      .rs1Data (rs1Data),
      .rs2Data (rs2Data),
      .rdIn    (rdIn),
      .flush   (flush),
      .ready   (ready),
      .busy    (busy),
      .valid   (valid),
      .result  (result),
      .rdOut   (rdOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [W-1:0] res;
      logic [R-1:0] rd;
      int           acceptCycle;
      int           lat;
   } exp_t;

   typedef struct {
      string        name;
      logic [2:0]   f;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [R-1:0] rd;
      logic [W-1:0] res;
      int           lat;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   cycleCnt = 0;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rstN && valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got valid=1 rdOut=%0d result=0x%0h, required no result", rdOut, result);
         end else begin
            e = sb.pop_front();
            check({e.name, "_result"}, result, e.res);
            check({e.name, "_rd"}, W'(rdOut), W'(e.rd));
            check({e.name, "_latency"}, W'(cycleCnt - e.acceptCycle + 1), W'(e.lat));
         end
      end
   end

   // Wait for ready, present one request for one cycle; optionally score it
   task automatic issue(input string name, input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [R-1:0] rd,
                        input logic [W-1:0] res, input int lat, input bit scored);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!ready) begin
         checks++;
         errors++;
         $display("FAIL %s_ready_timeout: got ready=0, required ready=1 within 200 cycles", name);
         return;
      end
      func3   = f;
      rs1Data = a;
      rs2Data = b;
      rdIn    = rd;
      start   = 1'b1;
      if (scored) sb.push_back('{name, res, rd, cycleCnt + 1, lat});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input string name);
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_drain_timeout: got %0d pending results, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [W-1:0] lastRes;
      logic [R-1:0] lastRd;

      rstN    = 1'b0;
      start   = 1'b0;
      flush   = 1'b0;
      func3   = '0;
      rs1Data = '0;
      rs2Data = '0;
      rdIn    = '0;

      // Reset state
      #12;
      check("reset_ready",  W'(ready), W'(1));
      check("reset_busy",   W'(busy),  W'(0));
      check("reset_valid",  W'(valid), W'(0));
      check("reset_result", result,    '0);
      check("reset_rdOut",  W'(rdOut), W'(0));
      @(negedge clk);
      rstN = 1'b1;

      // First MUL: ready drops the cycle after accept, returns after W+1 cycles
      issue("mul_7_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, LAT_NORMAL, 1'b1);
      check("mul_ready_low", W'(ready), W'(0));
      check("mul_busy_high", W'(busy),  W'(1));
      drain("mul_7_m3");
      @(negedge clk);
      check("mul_ready_after", W'(ready), W'(1));
      check("mul_busy_after",  W'(busy),  W'(0));

      // Directed table, issued back to back
      vecs.push_back('{"mulh_min_min",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, LAT_NORMAL});
      vecs.push_back('{"mulhu_ones",     OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, LAT_NORMAL});
      vecs.push_back('{"mulhsu_ones",    OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, LAT_NORMAL});
      vecs.push_back('{"mul_min_min",    OP_MUL,    32'h8000_0000, 32'h8000_0000, 5'd4,  32'h0000_0000, LAT_NORMAL});
      vecs.push_back('{"div_m7_2",       OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, LAT_NORMAL});
      vecs.push_back('{"rem_m7_2",       OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, LAT_NORMAL});
      vecs.push_back('{"div_7_m2",       OP_DIV,    32'd7,         32'hFFFF_FFFE, 5'd8,  32'hFFFF_FFFD, LAT_NORMAL});
      vecs.push_back('{"rem_7_m2",       OP_REM,    32'd7,         32'hFFFF_FFFE, 5'd9,  32'h0000_0001, LAT_NORMAL});
      vecs.push_back('{"divu_100_7",     OP_DIVU,   32'd100,       32'd7,         5'd10, 32'd14,        LAT_NORMAL});
      vecs.push_back('{"remu_100_7",     OP_REMU,   32'd100,       32'd7,         5'd11, 32'd2,         LAT_NORMAL});
      vecs.push_back('{"div_5_0",        OP_DIV,    32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF, LAT_SPECIAL});
      vecs.push_back('{"remu_5_0",       OP_REMU,   32'd5,         32'd0,         5'd13, 32'd5,         LAT_SPECIAL});
      vecs.push_back('{"divu_9_0",       OP_DIVU,   32'd9,         32'd0,         5'd14, 32'hFFFF_FFFF, LAT_SPECIAL});
      vecs.push_back('{"rem_m9_0",       OP_REM,    32'hFFFF_FFF7, 32'd0,         5'd15, 32'hFFFF_FFF7, LAT_SPECIAL});
      vecs.push_back('{"div_ovf",        OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, LAT_SPECIAL});
      vecs.push_back('{"rem_ovf",        OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, LAT_SPECIAL});
      vecs.push_back('{"divu_big",       OP_DIVU,   32'hFFFF_FFFF, 32'h0001_0000, 5'd18, 32'h0000_FFFF, LAT_NORMAL});
      vecs.push_back('{"mulhu_min_2",    OP_MULHU,  32'h8000_0000, 32'd2,         5'd19, 32'h0000_0001, LAT_NORMAL});
      foreach (vecs[i]) begin
         issue(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res, vecs[i].lat, 1'b1);
      end
      drain("table");
      lastRes = 32'h0000_0001;
      lastRd  = 5'd19;

      // Flush on the 10th CALC cycle: no valid, ready next cycle, outputs unchanged
      issue("divu_flushed", OP_DIVU, 32'd1000, 32'd3, 5'd20, '0, LAT_NORMAL, 1'b0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_ready",  W'(ready), W'(1));
      check("flush_busy",   W'(busy),  W'(0));
      check("flush_valid",  W'(valid), W'(0));
      check("flush_result", result,    lastRes);
      check("flush_rdOut",  W'(rdOut), W'(lastRd));
      repeat (40) @(negedge clk);

      // start during CALC is ignored; original op completes with its own tag
      issue("mul_6_7", OP_MUL, 32'd6, 32'd7, 5'd9, 32'd42, LAT_NORMAL, 1'b1);
      repeat (5) @(negedge clk);
      func3   = OP_DIV;
      rs1Data = 32'd100;
      rs2Data = 32'd0;
      rdIn    = 5'd17;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("calc_start_ready", W'(ready), W'(0));
      drain("mul_6_7");

      // flush together with start in IDLE: nothing accepted
      @(negedge clk);
      func3   = OP_DIV;
      rs1Data = 32'd5;
      rs2Data = 32'd0;
      rdIn    = 5'd3;
      start   = 1'b1;
      flush   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("idle_flush_ready",  W'(ready), W'(1));
      check("idle_flush_busy",   W'(busy),  W'(0));
      check("idle_flush_result", result,    32'd42);
      repeat (3) @(negedge clk);

      // Asynchronous reset mid-CALC takes effect without a clock edge
      issue("mul_reset", OP_MUL, 32'h0000_1234, 32'h0000_5678, 5'd7, '0, LAT_NORMAL, 1'b0);
      repeat (10) @(negedge clk);
      #2;
      rstN = 1'b0;
      #1;
      check("arst_ready",  W'(ready), W'(1));
      check("arst_busy",   W'(busy),  W'(0));
      check("arst_valid",  W'(valid), W'(0));
      check("arst_result", result,    '0);
      check("arst_rdOut",  W'(rdOut), W'(0));
      @(negedge clk);
      rstN = 1'b1;
      issue("mul_3_4", OP_MUL, 32'd3, 32'd4, 5'd11, 32'd12, LAT_NORMAL, 1'b1);
      drain("mul_3_4");
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
